// File: rtl/bus_addr_decode.sv
// -----------------------------------------------------------------------------
// bus_addr_decode
//
// Front end of the MEM_IO memory/IO model. It sits between the 8088
// multiplexed bus and the MEM_IO instances. The block:
//   - latches the 20-bit address when ALE is high;
//   - decodes that address into one of four chip selects;
//   - forwards registered copies of the bus controls and the write data;
//   - returns read data to the CPU;
//   - tracks each bus cycle with a small FSM and keeps a sticky protocol-error
//     flag.
//
// Ports
//   CLK        clock; all state changes on the rising edge
//   RESET      synchronous, active-high; aborts any cycle in progress
//   ALE        address latch enable from the CPU
//   IOM        1 = I/O cycle, 0 = memory cycle
//   RD, WR     active-low read and write strobes
//   AD_in      multiplexed AD[7:0]: address low byte, or write data
//   A_hi       upper address bits A[19:8]
//   mem_rdata  OR of the MEM_IO data_out buses
//   AD_out     read data returned to the CPU
//   AD_OE      drive enable for AD_out
//   ALE_q      ALE delayed by one clock
//   IOM_q      IOM delayed by one clock
//   RD_q       RD delayed by one clock (active-low)
//   WR_q       WR delayed by one clock (active-low)
//   Address    latched address
//   wdata      write data for MEM_IO
//   CS1..CS4   chip selects; at most one is asserted
//   bus_err    sticky protocol-error flag, cleared only by RESET
// -----------------------------------------------------------------------------
module bus_addr_decode #(
   parameter int                    ADDR_WIDTH = 20,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [15:0]           IO1_BASE   = 16'hFF00,
   parameter logic [15:0]           IO2_BASE   = 16'h1C00,
   parameter logic [ADDR_WIDTH-1:0] MEM_SPLIT  = 20'h80000
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ALE,
   input  logic                  IOM,
   input  logic                  RD,
   input  logic                  WR,
   input  logic [DATA_WIDTH-1:0] AD_in,
   input  logic [ADDR_WIDTH-9:0] A_hi,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] AD_out,
   output logic                  AD_OE,
   output logic                  ALE_q,
   output logic                  IOM_q,
   output logic                  RD_q,
   output logic                  WR_q,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  CS1,
   output logic                  CS2,
   output logic                  CS3,
   output logic                  CS4,
   output logic                  bus_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_STROBE,
      S_END
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [3:0]              cs_q;          // bit 0 = CS1 ... bit 3 = CS4
   logic                    ale_dly_q, iom_dly_q, rd_dly_q, wr_dly_q;
   logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
   logic                    err_q;

   logic [ADDR_WIDTH-1:0]   new_addr;
   logic [3:0]              cs_dec;
   logic                    strobe_any;
   logic                    collide;
   logic                    wr_eff;
   logic                    err_set;
   logic                    cs_clr;

   // ---------------------------------------------------------------------
   // Address assembly and decode. The decode uses the incoming address so
   // that the chip selects are registered on the same edge as Address.
   // ---------------------------------------------------------------------
   assign new_addr = {A_hi, AD_in[7:0]};

   always_comb begin
      cs_dec = 4'b0000;
      if (IOM) begin
         cs_dec[0] = (new_addr[15:4] == IO1_BASE[15:4]);
         // CS1 wins if the two windows are ever set up to overlap, which keeps
         // the chip selects one-hot.
         cs_dec[1] = (new_addr[15:9] == IO2_BASE[15:9]) && !cs_dec[0];
      end else begin
         cs_dec[2] = (new_addr < MEM_SPLIT);
         cs_dec[3] = !cs_dec[2];
      end
   end

   // If RD and WR are both low, the cycle is treated as a read. The write
   // path (wdata capture and WR_q) is suppressed for that clock.
   assign strobe_any = !RD || !WR;
   assign collide    = !RD && !WR;
   assign wr_eff     = !WR && RD;

   // ---------------------------------------------------------------------
   // Bus-cycle FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      err_set = collide;
      cs_clr  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ALE) begin
               state_d = S_ADDR;
            end else if (strobe_any) begin
               // A strobe with no address phase: flag it and stay idle.
               err_set = 1'b1;
            end
         end
         S_ADDR: begin
            // If ALE stays high, the FSM keeps re-latching in ADDR. This is not
            // an error.
            if (!ALE) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ALE) begin
               state_d = S_ADDR;
               err_set = 1'b1;
            end else if (strobe_any) begin
               state_d = S_STROBE;
            end
         end
         S_STROBE: begin
            if (ALE) begin
               state_d = S_ADDR;
               err_set = 1'b1;
            end else if (!strobe_any) begin
               state_d = S_END;
            end
         end
         S_END: begin
            if (ALE) begin
               state_d = S_ADDR;
               err_set = 1'b1;
            end else begin
               state_d = S_IDLE;
               cs_clr  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cs_q      <= 4'b0000;
         ale_dly_q <= 1'b0;
         iom_dly_q <= 1'b0;
         rd_dly_q  <= 1'b1;
         wr_dly_q  <= 1'b1;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ale_dly_q <= ALE;
         iom_dly_q <= IOM;
         rd_dly_q  <= RD;
         wr_dly_q  <= !wr_eff;
         if (ALE) begin
            addr_q <= new_addr;
            cs_q   <= cs_dec;
         end else if (cs_clr) begin
            cs_q   <= 4'b0000;
         end
         if (wr_eff) wdata_q <= AD_in;
         if (!RD)    rdata_q <= mem_rdata;
         if (err_set) err_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign AD_OE   = (state_q == S_STROBE) && !rd_dly_q && (cs_q != 4'b0000);
   assign AD_out  = rdata_q;
   assign ALE_q   = ale_dly_q;
   assign IOM_q   = iom_dly_q;
   assign RD_q    = rd_dly_q;
   assign WR_q    = wr_dly_q;
   assign Address = addr_q;
   assign wdata   = wdata_q;
   assign CS1     = cs_q[0];
   assign CS2     = cs_q[1];
   assign CS3     = cs_q[2];
   assign CS4     = cs_q[3];
   assign bus_err = err_q;

endmodule
